// File: rtl/piso_pkg.sv
// Shared definitions for the piso word serializer: parameter defaults,
// the serializer state type and a ceiling-log2 helper for counter sizing.
package piso_pkg;

  localparam int DATA_WID_DEF   = 8;
  localparam int MEMORY_WID_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    for (v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso.sv
// Parallel-in/serial-out serializer: captures a block of MEMORY_WID words in
// one handshake and emits them word 0 first under valid/ready flow control.
module piso
  import piso_pkg::*;
#(
  parameter int DATA_WID   = DATA_WID_DEF,
  parameter int MEMORY_WID = MEMORY_WID_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [DATA_WID*MEMORY_WID-1:0] load_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WID-1:0]            out_data,
  output logic                           out_last
);

  localparam int CNT_W = clog2(MEMORY_WID + 1);

  piso_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_WID-1:0] mem_q [MEMORY_WID];
  logic [DATA_WID-1:0] mem_d [MEMORY_WID];
  logic                loadFire;
  logic                shiftFire;

  assign out_valid  = (state_q == SHIFT);
  assign out_data   = mem_q[0];
  assign out_last   = out_valid && (cnt_q == CNT_W'(1));
  // Ready on the last word lets the next block slide in with no bubble.
  assign load_ready = ~rst & (~out_valid | (out_ready & out_last));
  assign loadFire   = load_valid & load_ready;
  assign shiftFire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < MEMORY_WID; k++) begin
      mem_d[k] = mem_q[k];
    end

    if (loadFire) begin
      for (int k = 0; k < MEMORY_WID; k++) begin
        mem_d[k] = load_data[k*DATA_WID +: DATA_WID];
      end
      cnt_d   = CNT_W'(MEMORY_WID);
      state_d = SHIFT;
    end else if (shiftFire) begin
      for (int k = 0; k < MEMORY_WID - 1; k++) begin
        mem_d[k] = mem_q[k+1];
      end
      mem_d[MEMORY_WID-1] = '0;
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = (cnt_q == CNT_W'(1)) ? IDLE : SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int k = 0; k < MEMORY_WID; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < MEMORY_WID; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

endmodule
